// File: rtl/ws2812_frame_scheduler_if.sv
// Pixel RAM read port and encoder pixel stream used by the WS2812 frame scheduler.
interface ws2812_frame_scheduler_if #(
   parameter int ADDR_W = 8
);
   logic              mem_rd_en;
   logic              mem_bank;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [23:0]       mem_rd_data;
   logic [23:0]       pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              enc_idle;

   modport master (
      output mem_rd_en, mem_bank, mem_rd_addr, pix_data, pix_valid,
      input  mem_rd_data, pix_ready, enc_idle
   );

   modport slave (
      input  mem_rd_en, mem_bank, mem_rd_addr, pix_data, pix_valid,
      output mem_rd_data, pix_ready, enc_idle
   );
endinterface

// File: rtl/ws2812_frame_scheduler.sv
// Round-robin WS2812 frame scheduler: fetches a frame of GRB pixels from the granted
// requester's RAM bank, streams them to the bit encoder, then holds the latch low time.
//
// state   | meaning
// IDLE    | no frame; arbitrate req
// FETCH   | mem_rd_en high, RAM reads pixel at addr
// CAPTURE | RAM data valid, register into pix_data
// PRESENT | pix_valid high until encoder accepts
// DRAIN   | wait for encoder to shift out the last bits
// LATCH   | hold line low for LATCH_CYCLES cycles
// DONE    | frame_done pulse, grant released
module ws2812_frame_scheduler #(
   parameter int NUM_LEDS     = 16,
   parameter int ADDR_W       = 8,
   parameter int LATCH_CYCLES = 15000,
   parameter int LATCH_W      = 14
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       busy,
   output logic       frame_done,
   ws2812_frame_scheduler_if.master bus
);
   localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_LEDS - 1);
   localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, DRAIN, LATCH, DONE} state_t;

   state_t             state;
   logic               last;
   logic [ADDR_W-1:0]  addr;
   logic [LATCH_W-1:0] latch_cnt;
   logic               winner;

   // On contention the requester that did not own the previous frame wins.
   always_comb begin
      winner = 1'b0;
      case (req)
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last;
         default: winner = 1'b0;
      endcase
   end

   assign bus.mem_rd_addr = addr;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         last          <= 1'b1;
         addr          <= '0;
         latch_cnt     <= '0;
         gnt           <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         bus.mem_rd_en <= 1'b0;
         bus.mem_bank  <= 1'b0;
         bus.pix_data  <= '0;
         bus.pix_valid <= 1'b0;
      end else begin
         frame_done    <= 1'b0;
         bus.mem_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  gnt           <= winner ? 2'b10 : 2'b01;
                  bus.mem_bank  <= winner;
                  addr          <= '0;
                  busy          <= 1'b1;
                  bus.mem_rd_en <= 1'b1;
                  state         <= FETCH;
               end
            end
            FETCH: state <= CAPTURE;
            CAPTURE: begin
               bus.pix_data  <= bus.mem_rd_data;
               bus.pix_valid <= 1'b1;
               state         <= PRESENT;
            end
            PRESENT: begin
               if (bus.pix_ready) begin
                  bus.pix_valid <= 1'b0;
                  if (addr == LAST_ADDR) begin
                     state <= DRAIN;
                  end else begin
                     addr          <= addr + ADDR_W'(1);
                     bus.mem_rd_en <= 1'b1;
                     state         <= FETCH;
                  end
               end
            end
            DRAIN: begin
               if (bus.enc_idle) begin
                  latch_cnt <= '0;
                  state     <= LATCH;
               end
            end
            LATCH: begin
               if (latch_cnt == LATCH_LAST) begin
                  frame_done <= 1'b1;
                  last       <= gnt[1];
                  gnt        <= '0;
                  state      <= DONE;
               end else begin
                  latch_cnt <= latch_cnt + LATCH_W'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler: 4-pixel frames, 10-cycle latch, with a
// synchronous pixel RAM model and a scripted encoder handshake.
module tb_ws2812_frame_scheduler;
   localparam int NUM_LEDS     = 4;
   localparam int ADDR_W       = 8;
   localparam int LATCH_CYCLES = 10;
   localparam int LATCH_W      = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic [1:0] gnt;
   logic       busy;
   logic       frame_done;

   int errors = 0;
   int checks = 0;

   logic [23:0] ram [2][NUM_LEDS];
   logic [23:0] got [NUM_LEDS];
   int          pix_cnt, dur, viol, stall_bad;
   logic [1:0]  g0;

   ws2812_frame_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

   ws2812_frame_scheduler #(
      .NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W),
      .LATCH_CYCLES(LATCH_CYCLES), .LATCH_W(LATCH_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt),
      .busy(busy), .frame_done(frame_done), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_bank][bus.mem_rd_addr[1:0]];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs until frame_done (or budget), scripting pix_ready/enc_idle/req and
   // collecting handed-over pixels, frame duration and invariant violations.
   task automatic run_frame(input int stall_pix, input int stall_len, input int idle_hold,
                            input int drop0_pix, input int raise1_after);
      int n = 0;
      int t_fetch = -1;
      int stall_cnt = 0;
      int idle_cnt = 0;
      int after_last = -1;
      bit done = 1'b0;
      pix_cnt = 0; dur = -1; viol = 0; stall_bad = 0; g0 = 2'b00;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
         if (bus.mem_rd_en && t_fetch < 0) begin
            t_fetch = n;
            g0 = gnt;
         end
         if (gnt != 2'b00 && gnt != 2'b01 && gnt != 2'b10) viol++;
         if (gnt != 2'b00 && bus.mem_bank != gnt[1]) viol++;
         if (!frame_done && busy != (gnt != 2'b00)) viol++;
         if (!frame_done && busy && t_fetch >= 0 && gnt != g0) viol++;
         if (bus.mem_rd_en && (bus.pix_valid || bus.mem_rd_addr != ADDR_W'(pix_cnt))) viol++;
         if (drop0_pix >= 0 && pix_cnt == drop0_pix) req[0] = 1'b0;
         if (frame_done) begin
            dur  = (t_fetch >= 0) ? n - t_fetch : -1;
            done = 1'b1;
            if (gnt != 2'b00 || !busy) viol++;
         end
         if (after_last >= 0) begin
            after_last++;
            if (idle_cnt < idle_hold) begin
               bus.enc_idle = 1'b0;
               idle_cnt++;
            end else begin
               bus.enc_idle = 1'b1;
            end
            if (raise1_after >= 0 && after_last == raise1_after) req[1] = 1'b1;
         end
         if (pix_cnt == stall_pix && stall_cnt < stall_len && (bus.pix_valid || stall_cnt > 0)) begin
            bus.pix_ready = 1'b0;
            stall_cnt++;
            if (!bus.pix_valid || bus.pix_data !== ram[g0[1]][stall_pix] || bus.mem_rd_en)
               stall_bad++;
         end else begin
            bus.pix_ready = 1'b1;
         end
         if (bus.pix_valid && bus.pix_ready) begin
            if (pix_cnt < NUM_LEDS) got[pix_cnt] = bus.pix_data;
            pix_cnt++;
            if (pix_cnt == NUM_LEDS) after_last = 0;
         end
      end
      bus.enc_idle  = 1'b1;
      bus.pix_ready = 1'b1;
   endtask

   initial begin
      logic [1:0] exp_g;
      int         wait_n;
      ram[0][0] = 24'h0000FF; ram[0][1] = 24'h00FF00; ram[0][2] = 24'hFF0000; ram[0][3] = 24'h123456;
      ram[1][0] = 24'hA1A2A3; ram[1][1] = 24'hB1B2B3; ram[1][2] = 24'hC1C2C3; ram[1][3] = 24'hD1D2D3;
      bus.pix_ready = 1'b1;
      bus.enc_idle  = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_mem_rd_en", 32'(bus.mem_rd_en), 0);
      chk("rst_mem_bank", 32'(bus.mem_bank), 0);
      chk("rst_pix_valid", 32'(bus.pix_valid), 0);
      chk("rst_pix_data", 32'(bus.pix_data), 0);

      // Single requester, encoder always ready and idle.
      reset_n = 1'b1;
      req = 2'b01;
      run_frame(-1, 0, 0, -1, -1);
      for (int i = 0; i < NUM_LEDS; i++) chk($sformatf("s1_pix%0d", i), 32'(got[i]), 32'(ram[0][i]));
      chk("s1_pix_cnt", pix_cnt, NUM_LEDS);
      chk("s1_gnt", 32'(g0), 32'h1);
      chk("s1_dur", dur, 23);
      chk("s1_invariants", viol, 0);
      req = 2'b00;
      @(negedge clk);
      chk("s1_single_pulse", 32'(frame_done), 0);
      chk("s1_idle_busy", 32'(busy), 0);

      // Both requesters continuously asserting from reset alternate 0,1,0,1.
      reset_n = 1'b0;
      req = 2'b11;
      @(negedge clk);
      reset_n = 1'b1;
      for (int f = 0; f < 4; f++) begin
         exp_g = f[0] ? 2'b10 : 2'b01;
         run_frame(-1, 0, 0, -1, -1);
         chk($sformatf("s2_gnt_f%0d", f), 32'(g0), 32'(exp_g));
         chk($sformatf("s2_pix0_f%0d", f), 32'(got[0]), 32'(ram[exp_g[1]][0]));
         chk($sformatf("s2_pix3_f%0d", f), 32'(got[3]), 32'(ram[exp_g[1]][3]));
         chk($sformatf("s2_dur_f%0d", f), dur, 23);
         chk($sformatf("s2_invariants_f%0d", f), viol, 0);
      end

      // Encoder backpressure: 5 stall cycles on pixel 2.
      reset_n = 1'b0;
      req = 2'b01;
      @(negedge clk);
      reset_n = 1'b1;
      run_frame(2, 5, 0, -1, -1);
      for (int i = 0; i < NUM_LEDS; i++) chk($sformatf("s3_pix%0d", i), 32'(got[i]), 32'(ram[0][i]));
      chk("s3_stall_hold", stall_bad, 0);
      chk("s3_dur", dur, 28);
      chk("s3_invariants", viol, 0);
      req = 2'b00;
      @(negedge clk);

      // Encoder still shifting for 20 cycles after the last pixel.
      req = 2'b01;
      run_frame(-1, 0, 20, -1, -1);
      chk("s4_pix_cnt", pix_cnt, NUM_LEDS);
      chk("s4_dur", dur, 43);
      chk("s4_invariants", viol, 0);
      req = 2'b00;
      @(negedge clk);

      // req0 dropped during pixel 1, req1 raised during latch.
      req = 2'b01;
      run_frame(-1, 0, 0, 1, 5);
      chk("s5_pix_cnt", pix_cnt, NUM_LEDS);
      chk("s5_pix3", 32'(got[3]), 32'(ram[0][3]));
      chk("s5_gnt", 32'(g0), 32'h1);
      chk("s5_dur", dur, 23);
      chk("s5_invariants", viol, 0);
      @(negedge clk);
      chk("s5_idle_gnt", 32'(gnt), 0);
      chk("s5_idle_busy", 32'(busy), 0);
      @(negedge clk);
      chk("s5_next_gnt", 32'(gnt), 32'h2);
      chk("s5_next_fetch", 32'(bus.mem_rd_en), 1);

      // Reset mid-PRESENT while requester 1 owns the frame and last points at 0.
      bus.pix_ready = 1'b0;
      req = 2'b11;
      wait_n = 0;
      while (!bus.pix_valid && wait_n < 10) begin
         @(negedge clk);
         wait_n++;
      end
      chk("s6_reached_present", 32'(bus.pix_valid), 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("s6_rst_gnt", 32'(gnt), 0);
      chk("s6_rst_pix_valid", 32'(bus.pix_valid), 0);
      chk("s6_rst_busy", 32'(busy), 0);
      chk("s6_rst_frame_done", 32'(frame_done), 0);
      reset_n = 1'b1;
      run_frame(-1, 0, 0, -1, -1);
      chk("s6_first_gnt", 32'(g0), 32'h1);
      chk("s6_dur", dur, 23);
      chk("s6_invariants", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
- Sequences refresh frames for the WS2812 RGB LED chain that drives the on-board and external LED data line.
- Arbitrates between two frame requesters: requester 0 is the CPU frame buffer, requester 1 is the pattern engine buffer.
- For each granted frame, fetches NUM_LEDS 24-bit GRB words from that requester's pixel-RAM bank and hands them one at a time to the downstream WS2812 bit encoder over a valid/ready handshake.
- After the last pixel it waits for the encoder to drain, then enforces the chain latch low time before the next frame may start.

Parameters:
- NUM_LEDS, 16, pixels per frame (1..2^ADDR_W).
- ADDR_W, 8, pixel RAM address width.
- LATCH_CYCLES, 15000, latch/reset low time in clk cycles (300 us at 50 MHz); must be >= 1.
- LATCH_W, 14, latch counter width; must satisfy 2^LATCH_W > LATCH_CYCLES.

Ports:
- clk, in, 1, system clock (50 MHz).
- reset_n, in, 1, synchronous active-low reset.
- req, in, 2, per-requester frame request (level); sampled only in IDLE.
- gnt, out, 2, one-hot grant, held for the whole frame including latch.
- busy, out, 1, high in every state except IDLE.
- frame_done, out, 1, one-cycle pulse at end of frame.
- mem_rd_en, out, 1, pixel RAM read strobe.
- mem_bank, out, 1, RAM bank select; equals the granted requester index.
- mem_rd_addr, out, ADDR_W, pixel index.
- mem_rd_data, in, 24, RAM read data, valid exactly 1 cycle after mem_rd_en.
- pix_data, out, 24, pixel to the encoder.
- pix_valid, out, 1, pixel valid.
- pix_ready, in, 1, encoder accepts the pixel.
- enc_idle, in, 1, encoder has shifted out all bits.

Behaviour:
- Reset: the only reset is synchronous (sampled on the clk edge while reset_n = 0). All outputs go to 0. State goes to IDLE. The round-robin pointer last goes to 1, so requester 0 wins the first contention. The address counter and latch counter clear.
- An assertion of reset_n = 0 mid-frame aborts the frame: pix_valid drops at that edge, and no frame_done is generated.
- IDLE:
  - If req == 00, stay in IDLE.
  - Otherwise select a winner. If only one requester is asserting, it wins. If both are asserting, the winner is the requester not equal to last.
  - Set gnt[winner], set mem_bank = winner, set addr = 0, then go to FETCH.
- FETCH (1 cycle): mem_rd_en = 1 with mem_rd_addr = addr. Go to CAPTURE.
- CAPTURE (1 cycle): register pix_data <= mem_rd_data and set pix_valid = 1 from the next cycle. Go to PRESENT.
- PRESENT:
  - Hold pix_data and pix_valid stable until the cycle in which pix_valid & pix_ready.
  - On that handshake: pix_valid <= 0. If addr == NUM_LEDS-1, go to DRAIN; else addr <= addr+1 and go to FETCH.
  - The minimum pixel period is 3 cycles.
- DRAIN: wait until enc_idle = 1, then clear the latch counter and go to LATCH.
- LATCH:
  - Count from 0 to LATCH_CYCLES-1.
  - On the cycle the count equals LATCH_CYCLES-1, go to DONE.
  - LATCH lasts exactly LATCH_CYCLES cycles.
- DONE (1 cycle): frame_done = 1, last <= granted index, gnt <= 00. Go to IDLE.
- Re-arbitration: IDLE therefore lasts at least 1 cycle between frames. Requests still high are re-arbitrated there. With both requesters continuously asserting, grants alternate 0,1,0,1.
- Request deassertion mid-frame is ignored; the frame completes. req is not sampled outside IDLE.
- mem_rd_en is never asserted outside FETCH.
- pix_valid is never asserted outside PRESENT.
- The address counter never exceeds NUM_LEDS-1, so there is no wrap.
- NUM_LEDS = 1: PRESENT goes directly to DRAIN after the first handshake.
- pix_ready held high continuously is legal; the handshake completes on the first PRESENT cycle.
- enc_idle already high on entry to DRAIN: DRAIN lasts 1 cycle.
- Invariants: gnt is one-hot or zero; busy == (gnt != 0) except in IDLE/DONE, where gnt is zero.

Test Plan:
- NUM_LEDS=4, LATCH_CYCLES=10, req=01, pix_ready=1, enc_idle=1, RAM bank0 = {0x0000FF, 0x00FF00, 0xFF0000, 0x123456}:
  - pix_data sequence matches RAM exactly.
  - mem_bank = 0 and gnt = 01 throughout.
  - frame_done pulses once, 4×3 + 1 (DRAIN) + 10 (LATCH) cycles after FETCH first entered.
- req=11 held continuously from reset for 4 frames: gnt order is 01, 10, 01, 10, and mem_bank follows gnt.
- Backpressure: pix_ready low for 5 cycles on pixel 2:
  - pix_valid and pix_data stay at 0xFF0000 during the stall.
  - mem_rd_en stays low during the stall.
  - Frame completes 5 cycles later than in the first scenario.
- enc_idle held low for 20 cycles after the last handshake: the latch counter does not start until enc_idle = 1, and frame_done is delayed by 20 cycles.
- req0 dropped in the middle of pixel 1: all 4 pixels are still sent and frame_done pulses. req1 raised during LATCH is granted only after DONE and one IDLE cycle.
- reset_n low for 1 cycle during PRESENT:
  - Next cycle gnt=00, pix_valid=0, busy=0, frame_done never asserted.
  - With req=11 after reset, requester 0 is granted first.
